// File: rtl/legv8_mem_pkg.sv
// legv8_mem_pkg: shared state encoding, grant IDs and default widths for the LEGv8 memory port.
package legv8_mem_pkg;
  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    BUSY_IF = 2'b01,
    BUSY_D  = 2'b10
  } state_t;
  localparam logic GNT_IF = 1'b0;
  localparam logic GNT_D = 1'b1;
  localparam int ADDR_W_DEF = 64;
  localparam int DATA_W_DEF = 64;
  localparam int TIMEOUT_DEF = 15;
endpackage

// File: rtl/wait_counter.sv
// wait_counter: 8-bit wait-state counter; expired flags the increment that would reach TIMEOUT.
module wait_counter #(
  parameter int TIMEOUT = 15
) (
  input  logic clock,
  input  logic reset,
  input  logic clr,
  input  logic en,
  output logic expired
);
  logic [7:0] count;
  always_ff @(posedge clock or posedge reset)
    if (reset) count <= '0;
    else if (clr) count <= '0;
    else if (en) count <= count + 8'd1;
  assign expired = en && (count + 8'd1 == 8'(TIMEOUT));
endmodule

// File: rtl/mem_port_arbiter_legv8.sv
// mem_port_arbiter_legv8: round-robin arbiter sharing one memory port between fetch and data requesters.
module mem_port_arbiter_legv8
  import legv8_mem_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF,
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_ack,
  output logic              if_err,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_ack,
  output logic              d_err,
  output logic [DATA_W-1:0] d_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ready,
  output logic              busy
);
  state_t state, state_nxt;
  logic last_grant, if_el, d_el, gnt_if, gnt_d, cnt_clr, cnt_en, expired, done;
  // A requester is masked during its own ack cycle so a held level req is not re-granted.
  assign if_el = if_req && !if_ack;
  assign d_el = d_req && !d_ack;
  assign gnt_d = d_el && (!if_el || last_grant == GNT_IF);
  assign gnt_if = if_el && !gnt_d;
  assign cnt_clr = state == IDLE;
  assign cnt_en = state != IDLE && !mem_ready;
  assign done = state != IDLE && (mem_ready || expired);
  wait_counter #(.TIMEOUT(TIMEOUT)) u_wait (
    .clock(clock),
    .reset(reset),
    .clr(cnt_clr),
    .en(cnt_en),
    .expired(expired)
  );
  always_ff @(posedge clock or posedge reset)
    if (reset) state <= IDLE;
    else state <= state_nxt;
  always_comb begin
    state_nxt = state;
    if (state == IDLE) state_nxt = gnt_d ? BUSY_D : gnt_if ? BUSY_IF : IDLE;
    else if (done) state_nxt = IDLE;
  end
  always_comb begin
    mem_en = state != IDLE;
    busy = state != IDLE;
  end
  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      mem_we <= 1'b0;
      mem_addr <= '0;
      mem_wdata <= '0;
      last_grant <= GNT_D;
      if_ack <= 1'b0;
      if_err <= 1'b0;
      if_rdata <= '0;
      d_ack <= 1'b0;
      d_err <= 1'b0;
      d_rdata <= '0;
    end else begin
      if_ack <= 1'b0;
      if_err <= 1'b0;
      d_ack <= 1'b0;
      d_err <= 1'b0;
      if (state == IDLE && (gnt_if || gnt_d)) begin
        mem_addr <= gnt_d ? d_addr : if_addr;
        if (gnt_d) mem_wdata <= d_wdata;
        mem_we <= gnt_d && d_we;
        last_grant <= gnt_d ? GNT_D : GNT_IF;
      end else if (done) begin
        mem_we <= 1'b0;
        if (state == BUSY_IF) begin
          if_ack <= 1'b1;
          if_err <= !mem_ready;
          if (mem_ready) if_rdata <= mem_rdata;
        end else begin
          d_ack <= 1'b1;
          d_err <= !mem_ready;
          if (mem_ready && !mem_we) d_rdata <= mem_rdata;
        end
      end
    end
endmodule

// File: tb/tb_mem_port_arbiter_legv8.sv
// tb_mem_port_arbiter_legv8: directed scenario bench for the LEGv8 memory port arbiter.
module tb_mem_port_arbiter_legv8;
  logic clock = 1'b0, reset = 1'b1;
  logic if_req = 1'b0, d_req = 1'b0, d_we = 1'b0, mem_ready = 1'b0;
  logic [63:0] if_addr = '0, d_addr = '0, d_wdata = '0, mem_rdata = '0;
  logic if_ack, if_err, d_ack, d_err, mem_en, mem_we, busy;
  logic [63:0] if_rdata, d_rdata, mem_addr, mem_wdata;
  int tests = 0, fails = 0;

  mem_port_arbiter_legv8 #(.ADDR_W(64), .DATA_W(64), .TIMEOUT(15)) dut (
    .clock(clock), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_ack(if_ack), .if_err(if_err), .if_rdata(if_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_ack(d_ack), .d_err(d_err), .d_rdata(d_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ready(mem_ready), .busy(busy)
  );

  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    tick();
    #2 reset = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick();
    tests++;
    if ({mem_en, mem_we, busy, if_ack, if_err, d_ack, d_err} !== 7'b0) begin
      fails++;
      $display("FAIL reset_ctrl got=%b want=0", {mem_en, mem_we, busy, if_ack, if_err, d_ack, d_err});
    end
    tests++;
    if (mem_addr !== 64'h0 || mem_wdata !== 64'h0 || if_rdata !== 64'h0 || d_rdata !== 64'h0) begin
      fails++;
      $display("FAIL reset_data addr=%h wdata=%h ird=%h drd=%h want 0", mem_addr, mem_wdata, if_rdata, d_rdata);
    end
    #2 reset = 1'b0;
    tick();
  endtask

  task automatic test_single_fetch();
    if_req = 1'b1;
    if_addr = 64'h40;
    tick();
    tests++;
    if (mem_en !== 1'b1 || mem_we !== 1'b0 || mem_addr !== 64'h40 || busy !== 1'b1) begin
      fails++;
      $display("FAIL fetch_issue en=%b we=%b addr=%h busy=%b want 1 0 40 1", mem_en, mem_we, mem_addr, busy);
    end
    tick();
    tests++;
    if (mem_en !== 1'b1 || if_ack !== 1'b0) begin
      fails++;
      $display("FAIL fetch_wait en=%b ack=%b want 1 0", mem_en, if_ack);
    end
    mem_ready = 1'b1;
    mem_rdata = 64'hD65F03C0;
    tick();
    tests++;
    if (if_ack !== 1'b1 || if_err !== 1'b0 || if_rdata !== 64'hD65F03C0 || mem_en !== 1'b0) begin
      fails++;
      $display("FAIL fetch_done ack=%b err=%b rdata=%h en=%b want 1 0 d65f03c0 0", if_ack, if_err, if_rdata, mem_en);
    end
    if_req = 1'b0;
    mem_ready = 1'b0;
    tick();
    tests++;
    if (if_ack !== 1'b0 || mem_en !== 1'b0) begin
      fails++;
      $display("FAIL fetch_ack_pulse ack=%b en=%b want 0 0", if_ack, mem_en);
    end
  endtask

  task automatic test_simultaneous();
    do_reset();
    if_req = 1'b1;
    if_addr = 64'h100;
    d_req = 1'b1;
    d_we = 1'b1;
    d_addr = 64'h80;
    d_wdata = 64'h1234;
    tick();
    tests++;
    if (mem_en !== 1'b1 || mem_we !== 1'b0 || mem_addr !== 64'h100) begin
      fails++;
      $display("FAIL sim_if_first en=%b we=%b addr=%h want 1 0 100", mem_en, mem_we, mem_addr);
    end
    mem_ready = 1'b1;
    mem_rdata = 64'h55;
    tick();
    tests++;
    if (if_ack !== 1'b1 || mem_en !== 1'b0 || d_ack !== 1'b0) begin
      fails++;
      $display("FAIL sim_idle_gap if_ack=%b en=%b d_ack=%b want 1 0 0", if_ack, mem_en, d_ack);
    end
    if_req = 1'b0;
    mem_ready = 1'b0;
    tick();
    tests++;
    if (mem_en !== 1'b1 || mem_we !== 1'b1 || mem_addr !== 64'h80 || mem_wdata !== 64'h1234) begin
      fails++;
      $display("FAIL sim_store en=%b we=%b addr=%h wdata=%h want 1 1 80 1234", mem_en, mem_we, mem_addr, mem_wdata);
    end
    mem_ready = 1'b1;
    mem_rdata = 64'hFFFF;
    tick();
    tests++;
    if (d_ack !== 1'b1 || d_err !== 1'b0 || d_rdata !== 64'h0 || mem_we !== 1'b0) begin
      fails++;
      $display("FAIL sim_store_done ack=%b err=%b rdata=%h we=%b want 1 0 0 0", d_ack, d_err, d_rdata, mem_we);
    end
    d_req = 1'b0;
    d_we = 1'b0;
    mem_ready = 1'b0;
    tick();
  endtask

  task automatic test_starvation();
    if_addr = 64'h200;
    d_addr = 64'h300;
    d_we = 1'b0;
    if_req = 1'b1;
    d_req = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      if_req = 1'b1;
      d_req = 1'b1;
      tests++;
      if (mem_en !== 1'b1 || mem_addr !== ((i % 2 == 0) ? 64'h200 : 64'h300)) begin
        fails++;
        $display("FAIL starve_grant%0d en=%b addr=%h want 1 %h", i, mem_en, mem_addr, (i % 2 == 0) ? 64'h200 : 64'h300);
      end
      mem_ready = 1'b1;
      mem_rdata = 64'hA000 + 64'(i);
      tick();
      tests++;
      if ((i % 2 == 0) ? (if_ack !== 1'b1 || d_ack !== 1'b0 || if_rdata !== 64'hA000 + 64'(i))
                       : (d_ack !== 1'b1 || if_ack !== 1'b0 || d_rdata !== 64'hA000 + 64'(i))) begin
        fails++;
        $display("FAIL starve_ack%0d if_ack=%b d_ack=%b ird=%h drd=%h", i, if_ack, d_ack, if_rdata, d_rdata);
      end
      if (i % 2 == 0) if_req = 1'b0;
      else d_req = 1'b0;
      mem_ready = 1'b0;
    end
    if_req = 1'b0;
    d_req = 1'b0;
    tick();
  endtask

  task automatic test_timeout();
    d_req = 1'b1;
    d_we = 1'b0;
    d_addr = 64'h500;
    mem_ready = 1'b0;
    tick();
    for (int k = 1; k < 15; k++) begin
      tick();
      tests++;
      if (d_ack !== 1'b0 || mem_en !== 1'b1) begin
        fails++;
        $display("FAIL timeout_wait%0d ack=%b en=%b want 0 1", k, d_ack, mem_en);
      end
    end
    tick();
    tests++;
    if (d_ack !== 1'b1 || d_err !== 1'b1 || d_rdata !== 64'hA005 || mem_en !== 1'b0) begin
      fails++;
      $display("FAIL timeout_abort ack=%b err=%b rdata=%h en=%b want 1 1 a005 0", d_ack, d_err, d_rdata, mem_en);
    end
    d_req = 1'b0;
    tick();
    tests++;
    if (d_ack !== 1'b0 || d_err !== 1'b0) begin
      fails++;
      $display("FAIL timeout_pulse ack=%b err=%b want 0 0", d_ack, d_err);
    end
  endtask

  task automatic test_ready_at_timeout();
    if_req = 1'b1;
    if_addr = 64'h700;
    mem_ready = 1'b0;
    tick();
    for (int k = 1; k < 15; k++) tick();
    tests++;
    if (if_ack !== 1'b0 || mem_en !== 1'b1) begin
      fails++;
      $display("FAIL coincide_wait ack=%b en=%b want 0 1", if_ack, mem_en);
    end
    mem_ready = 1'b1;
    mem_rdata = 64'hBEEF;
    tick();
    tests++;
    if (if_ack !== 1'b1 || if_err !== 1'b0 || if_rdata !== 64'hBEEF) begin
      fails++;
      $display("FAIL coincide_done ack=%b err=%b rdata=%h want 1 0 beef", if_ack, if_err, if_rdata);
    end
    if_req = 1'b0;
    mem_ready = 1'b0;
    tick();
  endtask

  task automatic test_reset_mid();
    d_req = 1'b1;
    d_we = 1'b1;
    d_addr = 64'h900;
    d_wdata = 64'h77;
    tick();
    tests++;
    if (busy !== 1'b1 || mem_we !== 1'b1 || mem_addr !== 64'h900) begin
      fails++;
      $display("FAIL midrst_busy busy=%b we=%b addr=%h want 1 1 900", busy, mem_we, mem_addr);
    end
    tick();
    reset = 1'b1;
    #1;
    tests++;
    if ({mem_en, mem_we, busy, d_ack, d_err} !== 5'b0 || mem_addr !== 64'h0 || mem_wdata !== 64'h0 || if_rdata !== 64'h0) begin
      fails++;
      $display("FAIL midrst_clear ctl=%b addr=%h wdata=%h ird=%h want 0", {mem_en, mem_we, busy, d_ack, d_err}, mem_addr, mem_wdata, if_rdata);
    end
    if_req = 1'b1;
    if_addr = 64'hA00;
    tick();
    #2 reset = 1'b0;
    tests++;
    if (d_ack !== 1'b0 || mem_en !== 1'b0) begin
      fails++;
      $display("FAIL midrst_noack ack=%b en=%b want 0 0", d_ack, mem_en);
    end
    tick();
    tests++;
    if (mem_en !== 1'b1 || mem_addr !== 64'hA00 || mem_we !== 1'b0) begin
      fails++;
      $display("FAIL midrst_if_first en=%b addr=%h we=%b want 1 a00 0", mem_en, mem_addr, mem_we);
    end
    mem_ready = 1'b1;
    tick();
    if_req = 1'b0;
    d_req = 1'b0;
    mem_ready = 1'b0;
    tick();
  endtask

  initial begin
    test_reset();
    test_single_fetch();
    test_simultaneous();
    test_starvation();
    test_timeout();
    test_ready_at_timeout();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
